// File: rtl/calc_pkg.sv
// Shared definitions for the calculator driver: opcode encodings, the idle
// data value, the driver state enum and opcode classification helpers.
package calc_pkg;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SQR  = 3'd3;
  localparam logic [2:0] OP_ADD2 = 3'd4;
  localparam logic [2:0] OP_SUB2 = 3'd5;

  // Never a legal opcode, so the calculator cannot mistake it for one.
  localparam logic [7:0] IDLE_VAL = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_GAP,
    ST_SETTLE,
    ST_DONE
  } drv_state_t;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= OP_SUB2;
  endfunction

  function automatic logic is_binary(input logic [2:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/calc_golden.sv
// Combinational reference calculator; all arithmetic is modulo 256.
module calc_golden
  import calc_pkg::*;
(
  input  logic [7:0] opA,
  input  logic [7:0] opB,
  input  logic [2:0] opCode,
  output logic [7:0] expected
);

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    expected = IDLE_VAL;
    case (opCode)
      OP_MUL:  expected = opA * opB;
      OP_ADD:  expected = opA + opB;
      OP_SUB:  expected = opA - opB;
      OP_SQR:  expected = opA * opA;
      OP_ADD2: expected = opA + 8'd2;
      OP_SUB2: expected = opA - 8'd2;
      default: expected = IDLE_VAL;
    endcase
  end

endmodule

// File: rtl/calc_driver.sv
// Drives an entry sequence (A, op[, B]) into a calculator with timed strobes,
// samples its result and compares it against an internal golden value.
module calc_driver
  import calc_pkg::*;
#(
  parameter int unsigned GAP    = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] opA,
  input  logic [2:0] opCode,
  input  logic [7:0] opB,
  output logic       validIn,
  output logic [7:0] dataIn,
  input  logic [7:0] calcOut,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       mismatch,
  output logic       err
);

  localparam logic [3:0] GAP_LOAD    = 4'(GAP - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  drv_state_t r_state;
  drv_state_t w_next;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  logic [2:0] r_op_code;
  logic [1:0] r_entry;
  logic [3:0] r_cnt;
  logic [7:0] r_result;
  logic       r_mismatch;
  logic       r_err;
  logic [7:0] w_golden;
  logic       w_accept;
  logic       w_last_entry;
  logic       w_cnt_zero;

  calc_golden u_golden (
    .opA      (r_op_a),
    .opB      (r_op_b),
    .opCode   (r_op_code),
    .expected (w_golden)
  );

  assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_accept     = start && !busy;
  assign w_last_entry = is_binary(r_op_code) ? (r_entry == 2'd2) : (r_entry == 2'd1);
  assign w_cnt_zero   = (r_cnt == 4'd0);

  assign done     = (r_state == ST_DONE);
  assign validIn  = (r_state == ST_ENTER);
  assign result   = r_result;
  assign mismatch = r_mismatch;
  assign err      = r_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) w_next = is_legal(opCode) ? ST_ENTER : ST_DONE;
        else          w_next = ST_IDLE;
      end
      ST_ENTER:  w_next = w_last_entry ? ST_SETTLE : ST_GAP;
      ST_GAP:    if (w_cnt_zero) w_next = ST_ENTER;
      ST_SETTLE: if (w_cnt_zero) w_next = ST_DONE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dataIn = IDLE_VAL;
    if (r_state == ST_ENTER) begin
      case (r_entry)
        2'd0:    dataIn = r_op_a;
        2'd1:    dataIn = {5'd0, r_op_code};
        default: dataIn = r_op_b;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_code  <= '0;
      r_entry    <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_mismatch <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_a     <= opA;
        r_op_b     <= opB;
        r_op_code  <= opCode;
        r_entry    <= '0;
        r_mismatch <= 1'b0;
        r_err      <= !is_legal(opCode);
      end
      // One counter times both the inter-entry gap and the settle window.
      case (r_state)
        ST_ENTER: begin
          r_entry <= r_entry + 2'd1;
          r_cnt   <= w_last_entry ? SETTLE_LOAD : GAP_LOAD;
        end
        ST_GAP, ST_SETTLE: r_cnt <= r_cnt - 4'd1;
        default: ;
      endcase
      // Capture on the edge into DONE so result is already valid with done.
      if (r_state == ST_SETTLE && w_cnt_zero) begin
        r_result   <= calcOut;
        r_mismatch <= (calcOut != w_golden);
      end
    end
  end

endmodule

// File: tb/tb_calc_driver.sv
// Scoreboard bench for calc_driver paired with a behavioural calculator;
// directed vectors push expected entries/completions, a monitor checks them.
module tb_calc_driver;
  import calc_pkg::*;

  localparam int GAP    = 2;
  localparam int SETTLE = 2;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] opA    = 8'd0;
  logic [7:0] opB    = 8'd0;
  logic [2:0] opCode = 3'd0;
  logic       validIn;
  logic [7:0] dataIn;
  logic [7:0] calcOut;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       mismatch;
  logic       err;

  calc_driver #(.GAP(GAP), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opA      (opA),
    .opCode   (opCode),
    .opB      (opB),
    .validIn  (validIn),
    .dataIn   (dataIn),
    .calcOut  (calcOut),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mismatch (mismatch),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int         t;
    logic [7:0] res;
    logic       mm;
    logic       er;
  } done_exp_t;

  typedef struct {
    int         t;
    logic [7:0] d;
  } ent_exp_t;

  done_exp_t done_q[$];
  ent_exp_t  ent_q[$];
  done_exp_t m_d;
  ent_exp_t  m_e;
  logic      last_mm = 1'b0;
  logic      last_err = 1'b0;
  logic      corrupt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Behavioural calculator: latches entries, answers after the last one.
  logic [7:0] calc_q = 8'd0;
  logic [7:0] c_a = 8'd0;
  logic [7:0] c_op = 8'd0;
  int         c_step = 0;
  assign calcOut = calc_q;

  function automatic logic [7:0] calc_fn(input logic [7:0] a, input logic [7:0] op,
                                         input logic [7:0] b);
    logic [7:0] r;
    case (op)
      8'd0:    r = a * b;
      8'd1:    r = a + b;
      8'd2:    r = a - b;
      8'd3:    r = a * a;
      8'd4:    r = a + 8'd2;
      8'd5:    r = a - 8'd2;
      default: r = 8'hEE;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      c_step = 0;
      calc_q = 8'd0;
    end else if (validIn) begin
      case (c_step)
        0: begin
          c_a    = dataIn;
          c_step = 1;
        end
        1: begin
          c_op = dataIn;
          if (c_op >= 8'd3) begin
            calc_q = calc_fn(c_a, c_op, 8'd0) ^ {7'd0, corrupt};
            c_step = 0;
          end else begin
            c_step = 2;
          end
        end
        default: begin
          calc_q = calc_fn(c_a, c_op, dataIn) ^ {7'd0, corrupt};
          c_step = 0;
        end
      endcase
    end
  end

  // Monitor: every strobe and every done must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (validIn) begin
        if (ent_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_entry @cyc %0d: got dataIn %0d, expected no strobe", cyc, dataIn);
        end else begin
          m_e = ent_q.pop_front();
          check("entry_cycle", 32'(cyc), 32'(m_e.t));
          check("entry_data", 32'(dataIn), 32'(m_e.d));
        end
      end else begin
        check("idle_data", 32'(dataIn), 32'(IDLE_VAL));
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_done @cyc %0d: got done 1, expected 0", cyc);
        end else begin
          m_d = done_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(m_d.t));
          check("result", 32'(result), 32'(m_d.res));
          check("mismatch", 32'(mismatch), 32'(m_d.mm));
          check("err", 32'(err), 32'(m_d.er));
          check("busy_in_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Called at a negedge; waits for busy=0, presents the request, returns at
  // the negedge after the acceptance edge.
  task automatic issue(input logic [7:0] a, input logic [2:0] op, input logic [7:0] b,
                       input logic [7:0] exp_res, input logic exp_mm,
                       input bit keep_start, input bit abort);
    int        waited;
    int        t0;
    done_exp_t d;
    ent_exp_t  e;
    waited = 0;
    while (busy) begin
      waited++;
      if (waited > 40) begin
        n_vec++;
        n_fail++;
        $display("FAIL issue_timeout @cyc %0d: got busy 1, expected 0 within 40 cycles", cyc);
        return;
      end
      @(negedge clk);
    end
    check("hold_mismatch", 32'(mismatch), 32'(last_mm));
    check("hold_err", 32'(err), 32'(last_err));
    opA    = a;
    opB    = b;
    opCode = op;
    start  = 1'b1;
    t0     = cyc;
    if (op <= 3'd5) begin
      e.t = t0 + 1; e.d = a;            ent_q.push_back(e);
      e.t = t0 + 4; e.d = {5'd0, op};   ent_q.push_back(e);
      if (op <= 3'd2 && !abort) begin
        e.t = t0 + 7; e.d = b;          ent_q.push_back(e);
      end
    end
    if (!abort) begin
      d.t   = t0 + ((op <= 3'd2) ? 10 : (op <= 3'd5) ? 7 : 1);
      d.res = exp_res;
      d.mm  = exp_mm;
      d.er  = (op > 3'd5);
      done_q.push_back(d);
      last_mm  = exp_mm;
      last_err = (op > 3'd5);
    end
    @(negedge clk);
    if (!keep_start) start = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (done_q.size() != 0 || ent_q.size() != 0) begin
      waited++;
      if (waited > 60) begin
        n_vec++;
        n_fail++;
        $display("FAIL drain_timeout @cyc %0d: got %0d pending, expected 0", cyc,
                 done_q.size() + ent_q.size());
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_validIn"}, 32'(validIn), 32'd0);
    check({tag, "_dataIn"}, 32'(dataIn), 32'(IDLE_VAL));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b1;

    // a, op, b, expected result, expected mismatch, keep_start, abort
    issue(8'd7,   3'd0, 8'd6,   8'd42,  1'b0, 1'b0, 1'b0);
    issue(8'd200, 3'd1, 8'd100, 8'd44,  1'b0, 1'b0, 1'b0);
    issue(8'd5,   3'd2, 8'd9,   8'd252, 1'b0, 1'b0, 1'b0);
    issue(8'd1,   3'd4, 8'd0,   8'd3,   1'b0, 1'b0, 1'b0);
    issue(8'd16,  3'd3, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0);
    issue(8'd3,   3'd6, 8'd4,   8'd0,   1'b0, 1'b0, 1'b0);
    issue(8'd1,   3'd5, 8'd0,   8'd255, 1'b0, 1'b0, 1'b0);
    drain();

    // Calculator returns 3*5 with bit 0 flipped: 14 instead of 15.
    corrupt = 1'b1;
    issue(8'd3, 3'd0, 8'd5, 8'd14, 1'b1, 1'b0, 1'b0);
    drain();
    corrupt = 1'b0;

    // Reset at T0+5 of a binary op: two entries seen, then nothing.
    issue(8'd9, 3'd0, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("midrst");
    check("midrst_entries_left", 32'(ent_q.size()), 32'd0);
    last_mm  = 1'b0;
    last_err = 1'b0;
    rst = 1'b1;
    issue(8'd10, 3'd1, 8'd20, 8'd30, 1'b0, 1'b0, 1'b0);
    drain();

    // start held high: each new request lands in the previous DONE cycle.
    issue(8'd12,  3'd0, 8'd12, 8'd144, 1'b0, 1'b1, 1'b0);
    issue(8'd255, 3'd1, 8'd1,  8'd0,   1'b0, 1'b1, 1'b0);
    issue(8'd0,   3'd2, 8'd1,  8'd255, 1'b0, 1'b1, 1'b0);
    issue(8'd2,   3'd3, 8'd0,  8'd4,   1'b0, 1'b1, 1'b0);
    issue(8'd0,   3'd7, 8'd0,  8'd4,   1'b0, 1'b1, 1'b0);
    issue(8'd250, 3'd4, 8'd0,  8'd252, 1'b0, 1'b0, 1'b0);
    drain();
    repeat (5) @(negedge clk);
    check("final_done_pending", 32'(done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
